// File: rtl/cond_logic.sv
// Condition-check stage of the single-cycle ARM datapath: holds NZCV,
// evaluates Instr[31:28] against it and gates the decoder's write strobes.
module cond_logic #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic [3:0] flags_reg;
   logic [3:0] flags_next;
   logic       n, z, c, v;
   logic       cond_ex;

   assign {n, z, c, v} = flags_reg;

   // Decoded from the stored flags only, so an instruction never sees its own update.
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'h0: cond_ex = z;
         4'h1: cond_ex = ~z;
         4'h2: cond_ex = c;
         4'h3: cond_ex = ~c;
         4'h4: cond_ex = n;
         4'h5: cond_ex = ~n;
         4'h6: cond_ex = v;
         4'h7: cond_ex = ~v;
         4'h8: cond_ex = c & ~z;
         4'h9: cond_ex = ~c | z;
         4'hA: cond_ex = (n == v);
         4'hB: cond_ex = (n != v);
         4'hC: cond_ex = ~z & (n == v);
         4'hD: cond_ex = z | (n != v);
         4'hE: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // N,Z and C,V are separately enabled so logical ops can leave C,V intact.
   always_comb begin
      flags_next = flags_reg;
      if (FlagW[1] && cond_ex) flags_next[3:2] = ALUFlags[3:2];
      if (FlagW[0] && cond_ex) flags_next[1:0] = ALUFlags[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) flags_reg <= RESET_FLAGS;
      else       flags_reg <= flags_next;
   end

   assign CondEx   = cond_ex;
   assign Flags    = flags_reg;
   assign PCSrc    = PCS & cond_ex;
   assign RegWrite = RegW & cond_ex & ~NoWrite;
   assign MemWrite = MemW & cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: flag update, condition decode, strobe gating
// and asynchronous reset, checked with immediate assertions.
module tb_cond_logic;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] Cond = 4'h0;
   logic [3:0] ALUFlags = 4'h0;
   logic [1:0] FlagW = 2'b00;
   logic       PCS = 1'b1;
   logic       RegW = 1'b1;
   logic       MemW = 1'b1;
   logic       NoWrite = 1'b0;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;

   int compared = 0;
   int mismatched = 0;

   cond_logic dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .CondEx(CondEx), .Flags(Flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit past it.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] f);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
      edge1();
      FlagW = 2'b00;
   endtask

   initial begin
      // 1: reset, then release
      #1 reset = 1'b1;
      #2;
      check("rst_flags", Flags, 4'b0000);
      check("rst_condex_eq", {3'b0, CondEx}, 4'd0);
      check("rst_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_flags", Flags, 4'b0000);
      check("post_rst_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
      Cond = 4'hE; #1;
      check("al_condex", {3'b0, CondEx}, 4'd1);
      check("al_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
      $display("step1 reset/AL: flags=%b", Flags);

      // 2: SUB 5-3 -> C set
      load(4'b0010);
      check("sub53_flags", Flags, 4'b0010);
      Cond = 4'h2; #1; check("cs", {3'b0, CondEx}, 4'd1);
      Cond = 4'h8; #1; check("hi", {3'b0, CondEx}, 4'd1);
      Cond = 4'h9; #1; check("ls", {3'b0, CondEx}, 4'd0);
      $display("step2 SUB 5-3: flags=%b", Flags);

      // 3: LT against old flags, then SUB 3-5 -> N set
      Cond = 4'hB; #1; check("lt_old_flags", {3'b0, CondEx}, 4'd0);
      load(4'b1000);
      check("sub35_flags", Flags, 4'b1000);
      Cond = 4'hB; #1; check("lt", {3'b0, CondEx}, 4'd1);
      Cond = 4'hA; #1; check("ge", {3'b0, CondEx}, 4'd0);
      Cond = 4'h4; #1; check("mi", {3'b0, CondEx}, 4'd1);
      Cond = 4'hD; #1; check("le", {3'b0, CondEx}, 4'd1);
      Cond = 4'hC; #1; check("gt", {3'b0, CondEx}, 4'd0);
      $display("step3 SUB 3-5: flags=%b", Flags);

      // 4: partial write keeps C,V; failed condition blocks update
      load(4'b0110);
      check("load_0110", Flags, 4'b0110);
      Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1001;
      edge1();
      check("flagw10", Flags, 4'b1010);
      Cond = 4'h0; FlagW = 2'b10; ALUFlags = 4'b0101; #1;
      check("eq_false", {3'b0, CondEx}, 4'd0);
      edge1();
      check("eq_false_hold", Flags, 4'b1010);
      FlagW = 2'b00;
      $display("step4 partial write: flags=%b", Flags);

      // 5: NoWrite gating, Cond=F never
      Cond = 4'hE; RegW = 1'b1; NoWrite = 1'b1; #1;
      check("nowrite1", {3'b0, RegWrite}, 4'd0);
      NoWrite = 1'b0; #1;
      check("nowrite0", {3'b0, RegWrite}, 4'd1);
      Cond = 4'hF; #1;
      check("nv_out", {PCSrc, RegWrite, MemWrite, CondEx}, 4'b0000);
      FlagW = 2'b11; ALUFlags = 4'b0101;
      edge1();
      check("nv_hold", Flags, 4'b1010);
      PCS = 1'bx; RegW = 1'bx; MemW = 1'bx; #1;
      check("nv_xsafe", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b0111;
      edge1();
      check("flagw01", Flags, 4'b1011);
      FlagW = 2'b00;
      $display("step5 gating: flags=%b", Flags);

      // 6: asynchronous reset mid-cycle, held across an edge
      load(4'b1111);
      check("load_1111", Flags, 4'b1111);
      reset = 1'b1; #1;
      check("async_rst", Flags, 4'b0000);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
      edge1();
      check("rst_held_edge", Flags, 4'b0000);
      reset = 1'b0;
      edge1();
      check("after_rst_load", Flags, 4'b0100);
      FlagW = 2'b00; Cond = 4'h0; #1;
      check("eq_after_load", {3'b0, CondEx}, 4'd1);
      $display("step6 reset mid-cycle: flags=%b", Flags);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface in the single-cycle ARM datapath.
- Holds the architectural NZCV flags and updates them from `ALUFlags` under `FlagW` control.
- Evaluates the 4-bit instruction condition field against the stored flags.
- Gates the decoder's write and branch strobes, so instructions whose condition fails have no architectural effect.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into the NZCV register on reset, ordered {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  flags from the ALU, {N,Z,C,V} in bits [3:0].
- FlagW  input  2  flag-write request from the decoder; [1] writes N,Z and [0] writes C,V.
- PCS  input  1  decoder request to write the PC (branch, or write to R15).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  decoder suppresses the register write (CMP/CMN/TST).
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed, computed from the stored flags.
- Flags  output  4  current stored {N,Z,C,V}.

Behaviour:
- Reset:
  - While reset=1, Flags = RESET_FLAGS immediately (asynchronous), independent of clk.
  - All outputs then follow combinationally from those flags.
  - With default parameters and Cond=4'hE, CondEx=1; with Cond=4'h0, CondEx=0.
- Flag register is two independently enabled halves:
  - Flags[3:2] <= ALUFlags[3:2] on the rising clk when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] on the rising clk when FlagW[0] & CondEx.
  - Otherwise each half holds its value.
- CondEx is combinational from the registered Flags, never from ALUFlags:
  - An instruction's own flag update cannot affect its own CondEx.
  - The update becomes visible one cycle later, to the next instruction.
  - Latency from ALUFlags to Flags is 1 clock.
- Condition decode, with N,Z,C,V taken from Flags:
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 MI: N.
  - 5 PL: !N.
  - 6 VS: V.
  - 7 VC: !V.
  - 8 HI: C & !Z.
  - 9 LS: !C | Z.
  - A GE: N==V.
  - B LT: N!=V.
  - C GT: !Z & (N==V).
  - D LE: Z | (N!=V).
  - E AL: 1.
  - F: 0. This encoding is unsupported, so it is treated as never: no writes of any kind and no flag update.
- Output gating, all combinational, no added latency:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Simultaneous events:
  - FlagW=2'b11 with CondEx=1: all four bits update on the same edge.
  - FlagW=2'b10 (e.g. logical ops): C and V are preserved.
  - FlagW asserted while CondEx=0: no update.
- Reset mid-operation:
  - Asserting reset between edges clears Flags at once.
  - A rising clk while reset=1 never loads ALUFlags.
  - On deassertion, the first rising edge with an enabled FlagW loads normally.
- X-safety: with CondEx=0, no output depends on PCS, RegW or MemW.

Test Plan:
1. Reset with Cond=4'h0, then release -> Flags=4'b0000, CondEx=0, PCSrc=RegWrite=MemWrite=0 even with PCS=RegW=MemW=1. Then set Cond=4'hE -> CondEx=1, all three strobes=1.
2. SUB 5-3 (ALUFlags=4'b0010), FlagW=2'b11, Cond=4'hE, one edge -> Flags=4'b0010. Next cycle: Cond=4'h2 (CS) gives CondEx=1, Cond=4'h8 (HI) gives 1, Cond=4'h9 (LS) gives 0.
3. SUB 3-5 (ALUFlags=4'b1000), FlagW=2'b11, one edge -> Flags=4'b1000. Then LT=1, GE=0, MI=1, LE=1, GT=0. Same-cycle check: before the edge, CondEx for Cond=4'hB still reflects the old flags 4'b0010, giving 0.
4. Flags=4'b0110, then FlagW=2'b10 with ALUFlags=4'b1001, one edge -> Flags=4'b1010 (C,V kept). Then repeat with Cond=4'h0 (EQ false) -> Flags unchanged at 4'b1010.
5. Cond=4'hE, RegW=1, NoWrite=1 -> RegWrite=0. With NoWrite=0 -> RegWrite=1. With Cond=4'hF -> CondEx=0, no strobes, and FlagW=2'b11 causes no update.
6. Flags=4'b1111, assert reset mid-cycle (no edge) -> Flags=4'b0000 immediately. Hold reset across an edge with FlagW=2'b11, ALUFlags=4'b0100 -> Flags stays 4'b0000.
